sume_init_sequencer: RTL and testbench
======================================

# sume_init_sequencer

Board bring-up sequencer for the SUME reference switch top level. It waits for the core clock MMCM to lock, then pulses the SI5324 jitter-cleaner reset. It next triggers the external I2C configuration engine and waits for the 10G transceiver reference to lock. Finally it releases the register-path and datapath resets in order, retrying the SI5324 programming on failure.

## Interface
- SI_RST_CYCLES, 1000: cycles si5324_rst_n is held low
- SETTLE_CYCLES, 2000: cycles to wait after SI5324 reset release before I2C start
- I2C_TIMEOUT, 1048576: maximum cycles to wait for i2c_done
- STAGGER_CYCLES, 16: cycles between reg_reset and dp_reset release
- MAX_RETRIES, 3: I2C attempts before entering FAIL (1..3)
- CNT_WIDTH, 24: timer width; must hold every cycle parameter above

- clk  in  1  core clock (200 MHz); the only clock
- reset  in  1  asynchronous, active-high
- clk_locked  in  1  core MMCM lock, synchronous to clk
- xphy_locked  in  1  156.25 MHz transceiver QPLL lock, pre-synchronised to clk
- i2c_start  out  1  one-cycle pulse that starts SI5324 programming
- i2c_done  in  1  one-cycle pulse: programming finished OK
- i2c_error  in  1  one-cycle pulse: programming NACK/abort
- si5324_rst_n  out  1  SI5324 reset, active-low
- reg_reset  out  1  AXI-Lite/register-block reset, active-high
- dp_reset  out  1  datapath (switch pipeline) reset, active-high
- init_done  out  1  high in RUN only
- init_fail  out  1  high in FAIL only
- retry_count  out  2  I2C attempts that failed so far
- state_o  out  4  current state encoding, for debug/register readback

## Operation
- States, encoded 0..7: WAIT_LOCK, SI_RST, SI_SETTLE, I2C_KICK, I2C_WAIT, XPHY_WAIT, STAGGER, RUN. FAIL is encoded 8.
- Reset values: state WAIT_LOCK, si5324_rst_n=1, reg_reset=1, dp_reset=1, i2c_start=0, init_done=0, init_fail=0, retry_count=0, timer=0.
- WAIT_LOCK -> SI_RST when clk_locked=1.
- SI_RST: si5324_rst_n=0 for exactly SI_RST_CYCLES cycles, then -> SI_SETTLE.
- SI_SETTLE: si5324_rst_n=1 for SETTLE_CYCLES cycles, then -> I2C_KICK.
- I2C_KICK: i2c_start=1 for one cycle, then -> I2C_WAIT.
- I2C_WAIT outcomes:
  - i2c_done -> XPHY_WAIT.
  - i2c_error, or timer reaching I2C_TIMEOUT with no done, counts as a failure and increments retry_count.
  - On failure, if retry_count+1 < MAX_RETRIES -> SI_RST; otherwise -> FAIL.
- XPHY_WAIT: wait for xphy_locked=1. On lock, clear reg_reset, then -> STAGGER.
- STAGGER: wait STAGGER_CYCLES cycles, then clear dp_reset and -> RUN.
- RUN: init_done=1. If xphy_locked=0: set dp_reset=1 and reg_reset=1, then -> XPHY_WAIT. No SI5324 re-program.
- FAIL: init_fail=1, all resets held, si5324_rst_n=1. It is terminal until reset is asserted.
- clk_locked=0 in any state except FAIL: next cycle -> WAIT_LOCK. All outputs return to reset values, except retry_count, which is preserved.
- Boundary conditions:
  - i2c_done and i2c_error in the same cycle: error wins.
  - i2c_done on the timeout cycle: done wins.
  - i2c_done/i2c_error outside I2C_WAIT: ignored.
  - retry_count saturates at MAX_RETRIES.
- Timer: reloaded to 0 on every state entry, increments each cycle, compared against (param-1), so the dwell is exactly param cycles.

## Timing
- All outputs are registered; no combinational path from input to output.
- Lock-loss response: one cycle from clk_locked falling to outputs at reset values.
- Reset assertion takes effect immediately (asynchronous). Release is synchronous to clk; the first state evaluation happens on the first clk edge after deassertion.
- Nominal bring-up latency once clk_locked=1 and I2C completes in D cycles (xphy already locked): SI_RST_CYCLES + SETTLE_CYCLES + 1 + D + 1 + STAGGER_CYCLES cycles to init_done=1.
- reg_reset falls exactly STAGGER_CYCLES+1 cycles before dp_reset.

## Test plan
- Test parameters: SI_RST_CYCLES=10, SETTLE_CYCLES=20, STAGGER_CYCLES=4, I2C_TIMEOUT=100, MAX_RETRIES=3.
- Normal bring-up: clk_locked=1, xphy_locked=1, i2c_done 5 cycles after i2c_start.
  - Required: si5324_rst_n low exactly 10 cycles; i2c_start single pulse 20 cycles after release.
  - Required: reg_reset falls, dp_reset falls 5 cycles later, init_done=1, retry_count=0.
- Single retry: i2c_error on attempt 1, i2c_done on attempt 2.
  - Required: a second 10-cycle si5324_rst_n pulse, retry_count=1, reaches RUN.
- Timeout to FAIL: i2c_done never asserted.
  - Required: three i2c_start pulses, each 131 cycles apart (10+20+1+100); then init_fail=1, retry_count=3, resets held.
- Lock loss mid-operation: drop clk_locked during SI_SETTLE.
  - Required: WAIT_LOCK next cycle with si5324_rst_n=1; re-lock restarts at SI_RST.
- xphy loss in RUN: drop xphy_locked for 50 cycles.
  - Required: dp_reset=reg_reset=1 and init_done=0 next cycle; no new i2c_start.
  - Required: on re-lock, resets release in the same 5-cycle stagger.
- Simultaneous events: i2c_done and i2c_error in the same cycle.
  - Required: treated as error, retry_count=1.
- Async reset: assert reset for 3 ns mid-I2C_WAIT.
  - Required: all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/sume_init_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : sume_init_sequencer                                          |
// | Description : SUME board bring-up sequencer. It waits for MMCM lock, pulses |
// |               the SI5324 reset, runs I2C programming with retries, waits   |
// |               for transceiver lock and then releases the staggered resets. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sume_init_sequencer #(
  parameter int SI_RST_CYCLES  = 1000,
  parameter int SETTLE_CYCLES  = 2000,
  parameter int I2C_TIMEOUT    = 1048576,
  parameter int STAGGER_CYCLES = 16,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_WIDTH      = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_locked,
  input  logic       xphy_locked,
  output logic       i2c_start,
  input  logic       i2c_done,
  input  logic       i2c_error,
  output logic       si5324_rst_n,
  output logic       reg_reset,
  output logic       dp_reset,
  output logic       init_done,
  output logic       init_fail,
  output logic [1:0] retry_count,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    ST_WAIT_LOCK = 4'd0,
    ST_SI_RST    = 4'd1,
    ST_SI_SETTLE = 4'd2,
    ST_I2C_KICK  = 4'd3,
    ST_I2C_WAIT  = 4'd4,
    ST_XPHY_WAIT = 4'd5,
    ST_STAGGER   = 4'd6,
    ST_RUN       = 4'd7,
    ST_FAIL      = 4'd8
  } state_e;

  localparam logic [CNT_WIDTH-1:0] c_si_rst_last  = CNT_WIDTH'(SI_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_settle_last  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_i2c_last     = CNT_WIDTH'(I2C_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] c_stagger_last = CNT_WIDTH'(STAGGER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_timer_one    = CNT_WIDTH'(1);
  localparam logic [2:0]           c_max_retries  = 3'(MAX_RETRIES);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   timer_q, timer_d;
  logic [1:0]             retry_q, retry_d;
  logic [2:0]             retry_inc;
  logic                   si_rst_n_q, si_rst_n_d;
  logic                   reg_reset_q, reg_reset_d;
  logic                   dp_reset_q, dp_reset_d;
  logic                   i2c_start_q, i2c_start_d;
  logic                   init_done_q, init_done_d;
  logic                   init_fail_q, init_fail_d;

  assign retry_inc = {1'b0, retry_q} + 3'd1;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;

    case (state_q)
      ST_WAIT_LOCK: if (clk_locked) state_d = ST_SI_RST;
      ST_SI_RST:    if (timer_q == c_si_rst_last) state_d = ST_SI_SETTLE;
      ST_SI_SETTLE: if (timer_q == c_settle_last) state_d = ST_I2C_KICK;
      ST_I2C_KICK:  state_d = ST_I2C_WAIT;
      ST_I2C_WAIT: begin
        // Error beats a simultaneous done; done beats the timeout.
        if (i2c_error || (!i2c_done && (timer_q == c_i2c_last))) begin
          if ({1'b0, retry_q} < c_max_retries) retry_d = retry_inc[1:0];
          state_d = (retry_inc < c_max_retries) ? ST_SI_RST : ST_FAIL;
        end else if (i2c_done) begin
          state_d = ST_XPHY_WAIT;
        end
      end
      // reg_reset is released first; move on only once it is already low.
      ST_XPHY_WAIT: if (xphy_locked && !reg_reset_q) state_d = ST_STAGGER;
      ST_STAGGER: begin
        if (!xphy_locked)                     state_d = ST_XPHY_WAIT;
        else if (timer_q == c_stagger_last)   state_d = ST_RUN;
      end
      ST_RUN:       if (!xphy_locked) state_d = ST_XPHY_WAIT;
      ST_FAIL:      state_d = ST_FAIL;
      default:      state_d = ST_WAIT_LOCK;
    endcase

    if (!clk_locked && (state_q != ST_FAIL)) begin
      state_d = ST_WAIT_LOCK;
      retry_d = retry_q;
    end

    timer_d = '0;
    if ((state_d == state_q) &&
        ((state_q == ST_SI_RST) || (state_q == ST_SI_SETTLE) ||
         (state_q == ST_I2C_WAIT) || (state_q == ST_STAGGER))) begin
      timer_d = timer_q + c_timer_one;
    end

    // Outputs are registered images of the state being entered.
    si_rst_n_d  = (state_d != ST_SI_RST);
    i2c_start_d = (state_d == ST_I2C_KICK);
    reg_reset_d = !((state_d == ST_STAGGER) || (state_d == ST_RUN) ||
                    ((state_d == ST_XPHY_WAIT) && xphy_locked));
    dp_reset_d  = (state_d != ST_RUN);
    init_done_d = (state_d == ST_RUN);
    init_fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT_LOCK;
      timer_q     <= '0;
      retry_q     <= 2'd0;
      si_rst_n_q  <= 1'b1;
      reg_reset_q <= 1'b1;
      dp_reset_q  <= 1'b1;
      i2c_start_q <= 1'b0;
      init_done_q <= 1'b0;
      init_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      si_rst_n_q  <= si_rst_n_d;
      reg_reset_q <= reg_reset_d;
      dp_reset_q  <= dp_reset_d;
      i2c_start_q <= i2c_start_d;
      init_done_q <= init_done_d;
      init_fail_q <= init_fail_d;
    end
  end

  assign i2c_start    = i2c_start_q;
  assign si5324_rst_n = si_rst_n_q;
  assign reg_reset    = reg_reset_q;
  assign dp_reset     = dp_reset_q;
  assign init_done    = init_done_q;
  assign init_fail    = init_fail_q;
  assign retry_count  = retry_q;
  assign state_o      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_sume_init_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_sume_init_sequencer                                       |
// | Description : Directed self-checking bench for sume_init_sequencer.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sume_init_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_locked = 1'b0;
  logic       xphy_locked = 1'b1;
  logic       i2c_done = 1'b0;
  logic       i2c_error = 1'b0;
  logic       i2c_start;
  logic       si5324_rst_n;
  logic       reg_reset;
  logic       dp_reset;
  logic       init_done;
  logic       init_fail;
  logic [1:0] retry_count;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sume_init_sequencer #(
    .SI_RST_CYCLES  (10),
    .SETTLE_CYCLES  (20),
    .I2C_TIMEOUT    (100),
    .STAGGER_CYCLES (4),
    .MAX_RETRIES    (3),
    .CNT_WIDTH      (24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_locked   (clk_locked),
    .xphy_locked  (xphy_locked),
    .i2c_start    (i2c_start),
    .i2c_done     (i2c_done),
    .i2c_error    (i2c_error),
    .si5324_rst_n (si5324_rst_n),
    .reg_reset    (reg_reset),
    .dp_reset     (dp_reset),
    .init_done    (init_done),
    .init_fail    (init_fail),
    .retry_count  (retry_count),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_locked = 1'b0; xphy_locked = 1'b1;
    i2c_done = 1'b0; i2c_error = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // Advances until i2c_start is seen; ok=0 if the cycle budget runs out.
  task automatic wait_kick(output int t, output bit ok);
    int n = 0;
    step();
    while (i2c_start !== 1'b1 && n < 400) begin step(); n++; end
    t = cyc;
    ok = (i2c_start === 1'b1);
  endtask

  task automatic test_reset();
    step();
    checks++; if (si5324_rst_n !== 1'b1) begin errors++; $display("FAIL rst_si_n got %b want 1", si5324_rst_n); end
    checks++; if (reg_reset !== 1'b1) begin errors++; $display("FAIL rst_reg got %b want 1", reg_reset); end
    checks++; if (dp_reset !== 1'b1) begin errors++; $display("FAIL rst_dp got %b want 1", dp_reset); end
    checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", i2c_start); end
    checks++; if ({init_done, init_fail} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {init_done, init_fail}); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL rst_retry got %0d want 0", retry_count); end
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state_o); end
    reset = 1'b0;
    step(); step();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL unlocked_state got %0d want 0", state_o); end
  endtask

  task automatic test_normal();
    int t_low, t_rel, t_kick, t_reg, n;
    bit ok;
    clk_locked = 1'b1; xphy_locked = 1'b1;
    step();
    t_low = cyc;
    checks++; if (si5324_rst_n !== 1'b0 || state_o !== 4'd1) begin errors++; $display("FAIL nrm_si_rst got n=%b st=%0d want n=0 st=1", si5324_rst_n, state_o); end
    n = 0; while (si5324_rst_n === 1'b0 && n < 200) begin step(); n++; end
    t_rel = cyc;
    checks++; if (t_rel - t_low !== 10) begin errors++; $display("FAIL nrm_si_low got %0d want 10", t_rel - t_low); end
    n = 0; while (i2c_start !== 1'b1 && n < 200) begin step(); n++; end
    t_kick = cyc;
    checks++; if (t_kick - t_rel !== 20) begin errors++; $display("FAIL nrm_kick_delay got %0d want 20", t_kick - t_rel); end
    step();
    checks++; if (i2c_start !== 1'b0 || state_o !== 4'd4) begin errors++; $display("FAIL nrm_pulse got s=%b st=%0d want s=0 st=4", i2c_start, state_o); end
    step(); step(); step(); step();
    i2c_done = 1'b1; step(); i2c_done = 1'b0;
    t_reg = cyc;
    checks++; if (reg_reset !== 1'b0 || dp_reset !== 1'b1) begin errors++; $display("FAIL nrm_reg_rel got r=%b d=%b want r=0 d=1", reg_reset, dp_reset); end
    n = 0; while (dp_reset !== 1'b0 && n < 50) begin step(); n++; end
    checks++; if (cyc - t_reg !== 5) begin errors++; $display("FAIL nrm_stagger got %0d want 5", cyc - t_reg); end
    checks++; if (cyc - t_low !== 41) begin errors++; $display("FAIL nrm_latency got %0d want 41", cyc - t_low); end
    checks++; if (init_done !== 1'b1 || state_o !== 4'd7 || retry_count !== 2'd0) begin errors++; $display("FAIL nrm_run got d=%b st=%0d r=%0d want 1 7 0", init_done, state_o, retry_count); end
    ok = 1'b1;
  endtask

  task automatic test_xphy_loss();
    int t_reg, n, kicks;
    kicks = 0;
    xphy_locked = 1'b0;
    step();
    checks++; if (dp_reset !== 1'b1 || reg_reset !== 1'b1 || init_done !== 1'b0) begin errors++; $display("FAIL xl_drop got d=%b r=%b done=%b want 1 1 0", dp_reset, reg_reset, init_done); end
    checks++; if (state_o !== 4'd5) begin errors++; $display("FAIL xl_state got %0d want 5", state_o); end
    for (int i = 0; i < 49; i++) begin step(); if (i2c_start === 1'b1) kicks++; end
    xphy_locked = 1'b1;
    step();
    t_reg = cyc;
    checks++; if (reg_reset !== 1'b0 || dp_reset !== 1'b1) begin errors++; $display("FAIL xl_reg_rel got r=%b d=%b want 0 1", reg_reset, dp_reset); end
    n = 0; while (dp_reset !== 1'b0 && n < 50) begin step(); n++; if (i2c_start === 1'b1) kicks++; end
    checks++; if (cyc - t_reg !== 5) begin errors++; $display("FAIL xl_stagger got %0d want 5", cyc - t_reg); end
    checks++; if (kicks !== 0 || init_done !== 1'b1) begin errors++; $display("FAIL xl_no_kick got kicks=%0d done=%b want 0 1", kicks, init_done); end
  endtask

  task automatic test_lock_loss();
    int n;
    do_reset();
    clk_locked = 1'b1;
    step();
    n = 0; while (si5324_rst_n === 1'b0 && n < 50) begin step(); n++; end
    step();
    i2c_error = 1'b1; step(); i2c_error = 1'b0;
    checks++; if (state_o !== 4'd2 || retry_count !== 2'd0) begin errors++; $display("FAIL ll_ignore_err got st=%0d r=%0d want 2 0", state_o, retry_count); end
    clk_locked = 1'b0;
    step();
    checks++; if (state_o !== 4'd0 || si5324_rst_n !== 1'b1 || i2c_start !== 1'b0) begin errors++; $display("FAIL ll_drop got st=%0d n=%b s=%b want 0 1 0", state_o, si5324_rst_n, i2c_start); end
    step();
    clk_locked = 1'b1;
    step();
    checks++; if (state_o !== 4'd1 || si5324_rst_n !== 1'b0) begin errors++; $display("FAIL ll_relock got st=%0d n=%b want 1 0", state_o, si5324_rst_n); end
  endtask

  task automatic test_retry();
    int k, t_low, n;
    bit ok;
    do_reset();
    clk_locked = 1'b1; xphy_locked = 1'b1;
    wait_kick(k, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rt_kick1 got none want pulse"); end
    step(); step();
    i2c_error = 1'b1; step(); i2c_error = 1'b0;
    t_low = cyc;
    checks++; if (state_o !== 4'd1 || retry_count !== 2'd1 || si5324_rst_n !== 1'b0) begin errors++; $display("FAIL rt_err got st=%0d r=%0d n=%b want 1 1 0", state_o, retry_count, si5324_rst_n); end
    n = 0; while (si5324_rst_n === 1'b0 && n < 50) begin step(); n++; end
    checks++; if (cyc - t_low !== 10) begin errors++; $display("FAIL rt_si_low got %0d want 10", cyc - t_low); end
    wait_kick(k, ok);
    step(); step(); step(); step(); step();
    i2c_done = 1'b1; step(); i2c_done = 1'b0;
    n = 0; while (init_done !== 1'b1 && n < 50) begin step(); n++; end
    checks++; if (init_done !== 1'b1 || retry_count !== 2'd1) begin errors++; $display("FAIL rt_run got done=%b r=%0d want 1 1", init_done, retry_count); end
  endtask

  task automatic test_simultaneous();
    int k;
    bit ok;
    do_reset();
    clk_locked = 1'b1;
    wait_kick(k, ok);
    step();
    i2c_done = 1'b1; i2c_error = 1'b1;
    step();
    i2c_done = 1'b0; i2c_error = 1'b0;
    checks++; if (state_o !== 4'd1 || retry_count !== 2'd1) begin errors++; $display("FAIL sim_err_wins got st=%0d r=%0d want 1 1", state_o, retry_count); end
  endtask

  task automatic test_async_reset();
    int k;
    bit ok;
    wait_kick(k, ok);
    step(); step();
    checks++; if (state_o !== 4'd4) begin errors++; $display("FAIL ar_pre got st=%0d want 4", state_o); end
    #1; reset = 1'b1;
    #2;
    checks++; if (state_o !== 4'd0 || retry_count !== 2'd0) begin errors++; $display("FAIL ar_state got st=%0d r=%0d want 0 0", state_o, retry_count); end
    checks++; if ({si5324_rst_n, reg_reset, dp_reset, i2c_start, init_done, init_fail} !== 6'b111000) begin errors++; $display("FAIL ar_outs got %b want 111000", {si5324_rst_n, reg_reset, dp_reset, i2c_start, init_done, init_fail}); end
    #1; reset = 1'b0;
  endtask

  task automatic test_timeout_fail();
    int t1, t2, t3;
    bit ok1, ok2, ok3;
    do_reset();
    clk_locked = 1'b1;
    wait_kick(t1, ok1);
    wait_kick(t2, ok2);
    checks++; if (!ok2 || t2 - t1 !== 131) begin errors++; $display("FAIL to_gap1 got %0d want 131", t2 - t1); end
    checks++; if (retry_count !== 2'd1) begin errors++; $display("FAIL to_retry1 got %0d want 1", retry_count); end
    wait_kick(t3, ok3);
    checks++; if (!ok3 || t3 - t2 !== 131) begin errors++; $display("FAIL to_gap2 got %0d want 131", t3 - t2); end
    for (int i = 0; i < 100; i++) step();
    checks++; if (state_o !== 4'd4 || init_fail !== 1'b0) begin errors++; $display("FAIL to_last_wait got st=%0d f=%b want 4 0", state_o, init_fail); end
    step();
    checks++; if (init_fail !== 1'b1 || state_o !== 4'd8 || retry_count !== 2'd3) begin errors++; $display("FAIL to_fail got f=%b st=%0d r=%0d want 1 8 3", init_fail, state_o, retry_count); end
    checks++; if ({si5324_rst_n, reg_reset, dp_reset, init_done} !== 4'b1110) begin errors++; $display("FAIL to_resets got %b want 1110", {si5324_rst_n, reg_reset, dp_reset, init_done}); end
    clk_locked = 1'b0; i2c_done = 1'b1;
    step(); step();
    i2c_done = 1'b0;
    checks++; if (state_o !== 4'd8 || init_fail !== 1'b1) begin errors++; $display("FAIL to_terminal got st=%0d f=%b want 8 1", state_o, init_fail); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_xphy_loss();
    test_lock_loss();
    test_retry();
    test_simultaneous();
    test_async_reset();
    test_timeout_fail();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
